// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multicycle CPU memory port.
package mips_mc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Byte address bits below WORD_LSB are dropped; the memory is word addressed.
  localparam int unsigned WORD_LSB        = 2;
  localparam int unsigned TIMEOUT_DEFAULT = 16;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Loadable up-counter with synchronous clear, enable and a terminal-count flag.
module mem_timeout_cnt #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned TERM  = 15
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(TERM);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TERM_VAL);

endmodule

// File: rtl/mem_port_unit.sv
// Memory port for the multicycle CPU: registered request/ready handshake to a
// variable-latency unified memory, IR/MDR holding registers and access timeout.
module mem_port_unit
  import mips_mc_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [AW-1:0]    i_pc,
  input  logic [AW-1:0]    i_alu_out,
  input  logic [DW-1:0]    i_store_data,
  input  logic             i_iord,
  input  logic             i_memread,
  input  logic             i_memwrite,
  input  logic             i_ir_write,
  input  logic             i_err_clr,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [AW-3:0]    o_mem_addr,
  output logic [DW-1:0]    o_mem_wdata,
  input  logic [DW-1:0]    i_mem_rdata,
  input  logic             i_mem_ready,
  output logic [DW-1:0]    o_instr,
  output logic [DW-1:0]    o_mdr,
  output logic             o_stall,
  output logic             o_bus_err
);

  localparam int unsigned CW = cnt_width(TIMEOUT);

  mem_state_t r_state, w_state_d;
  logic [AW-3:0] r_addr;
  logic          r_we;
  logic [DW-1:0] r_wdata;
  logic          r_irw;
  logic [DW-1:0] r_instr;
  logic [DW-1:0] r_mdr;
  logic          r_err;

  logic          w_idle, w_busy, w_issue, w_proto_err, w_done, w_abort, w_tc;
  logic [AW-1:0] w_sel_addr;
  logic          w_unused_addr_lsb;

  assign w_idle      = (r_state == IDLE);
  assign w_busy      = (r_state == BUSY);
  assign w_issue     = w_idle & (i_memread ^ i_memwrite);
  assign w_proto_err = w_idle & i_memread & i_memwrite;
  assign w_done      = w_busy & i_mem_ready;
  // Ready in the terminal cycle still completes the access normally.
  assign w_abort     = w_busy & ~i_mem_ready & w_tc;
  assign w_sel_addr  = i_iord ? i_alu_out : i_pc;

  assign w_unused_addr_lsb = ^{i_pc[WORD_LSB-1:0], i_alu_out[WORD_LSB-1:0]};

  mem_timeout_cnt #(
    .WIDTH (CW),
    .TERM  (TIMEOUT - 1)
  ) u_timeout_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (w_issue),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_busy & ~i_mem_ready),
    .o_tc       (w_tc)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE: if (w_issue) w_state_d = BUSY;
      BUSY: if (i_mem_ready || w_tc) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_irw   <= 1'b0;
      r_instr <= '0;
      r_mdr   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_issue) begin
        r_addr  <= w_sel_addr[AW-1:WORD_LSB];
        r_we    <= i_memwrite;
        r_wdata <= i_store_data;
        r_irw   <= i_ir_write;
      end
      if (w_done && !r_we) begin
        r_mdr <= i_mem_rdata;
        if (r_irw) r_instr <= i_mem_rdata;
      end
      if (w_proto_err || w_abort) begin
        r_err <= 1'b1;
      end else if (i_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign o_mem_req   = w_busy;
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_instr     = r_instr;
  assign o_mdr       = r_mdr;
  assign o_bus_err   = r_err;
  assign o_stall     = w_issue | (w_busy & ~i_mem_ready & ~w_tc);

endmodule

// File: tb/tb_mem_port_unit.sv
// Randomized self-checking bench for mem_port_unit against a transaction-level model.
module tb_mem_port_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 4;

  logic          clk;
  logic          reset;
  logic [AW-1:0] pc, alu_out;
  logic [DW-1:0] store_data;
  logic          iord, memread, memwrite, ir_write, err_clr;
  logic          mem_req, mem_we;
  logic [AW-3:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;
  logic [DW-1:0] instr, mdr;
  logic          stall, bus_err;

  int unsigned n_total;
  int unsigned n_bad;

  // Reference model: architectural view of IR, MDR and the error flag.
  logic [DW-1:0] m_instr, m_mdr;
  logic          m_err;

  mem_port_unit #(
    .DW      (DW),
    .AW      (AW),
    .TIMEOUT (TO)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_pc         (pc),
    .i_alu_out    (alu_out),
    .i_store_data (store_data),
    .i_iord       (iord),
    .i_memread    (memread),
    .i_memwrite   (memwrite),
    .i_ir_write   (ir_write),
    .i_err_clr    (err_clr),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .i_mem_ready  (mem_ready),
    .o_instr      (instr),
    .o_mdr        (mdr),
    .o_stall      (stall),
    .o_bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    memread   = 1'b0;
    memwrite  = 1'b0;
    ir_write  = 1'b0;
    err_clr   = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic check_arch(input string tag);
    check_eq({tag, "_instr"}, instr, m_instr);
    check_eq({tag, "_mdr"}, mdr, m_mdr);
    check_eq({tag, "_err"}, bus_err, m_err);
  endtask

  // One memory transaction; ws = BUSY cycles before ready (ws >= TO never answers).
  // Entered and left just after a rising edge with the DUT idle.
  task automatic access(input bit wr, input bit ad_sel, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input bit irw, input int ws,
                        input logic [DW-1:0] rdata);
    int unsigned   stalls;
    logic [AW-3:0] exp_a;
    stalls = 0;
    exp_a  = addr[AW-1:2];
    iord   = ad_sel;
    if (ad_sel) begin
      alu_out = addr;
      pc      = $urandom;
    end else begin
      pc      = addr;
      alu_out = $urandom;
    end
    store_data = wdata;
    memread    = !wr;
    memwrite   = wr;
    ir_write   = irw;
    mem_ready  = 1'b0;
    @(negedge clk);
    check_eq("issue_req", mem_req, 1'b0);
    if (stall) stalls++;
    next_cyc();
    for (int k = 0; k < int'(TO); k++) begin
      // Controller strobes are garbage while held; the port must ignore them.
      memread    = 1'($urandom);
      memwrite   = 1'($urandom);
      ir_write   = 1'($urandom);
      pc         = $urandom;
      alu_out    = $urandom;
      store_data = $urandom;
      mem_ready  = (k == ws);
      mem_rdata  = mem_ready ? rdata : DW'($urandom);
      @(negedge clk);
      check_eq("busy_req", mem_req, 1'b1);
      check_eq("busy_addr", mem_addr, exp_a);
      check_eq("busy_we", mem_we, wr);
      if (wr) check_eq("busy_wdata", mem_wdata, wdata);
      if (stall) stalls++;
      next_cyc();
      if (k == ws) break;
    end
    clear_strobes();
    if (ws < int'(TO)) begin
      if (!wr) begin
        m_mdr = rdata;
        if (irw) m_instr = rdata;
      end
    end else begin
      m_err = 1'b1;
    end
    #1;
    check_eq("done_req", mem_req, 1'b0);
    check_eq("stall_cycles", stalls, 1 + ((ws < int'(TO)) ? ws : int'(TO) - 1));
    check_arch("done");
  endtask

  task automatic idle_cyc(input bit both, input bit clr, input bit rdy);
    memread   = both;
    memwrite  = both;
    err_clr   = clr;
    mem_ready = rdy;
    mem_rdata = $urandom;
    @(negedge clk);
    check_eq("idle_stall", stall, 1'b0);
    check_eq("idle_req", mem_req, 1'b0);
    next_cyc();
    clear_strobes();
    if (both) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    #1;
    check_eq("idle_req_after", mem_req, 1'b0);
    check_arch("idle");
  endtask

  task automatic reset_mid_access();
    iord     = 1'b0;
    pc       = 32'h0000_0080;
    memread  = 1'b1;
    ir_write = 1'b1;
    next_cyc();
    clear_strobes();
    next_cyc();
    #2;
    reset = 1'b0;
    m_instr = '0;
    m_mdr   = '0;
    m_err   = 1'b0;
    #1;
    check_eq("rst_req", mem_req, 1'b0);
    check_eq("rst_addr", mem_addr, '0);
    check_arch("rst");
    @(negedge clk);
    reset = 1'b1;
    next_cyc();
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    reset      = 1'b0;
    pc         = '0;
    alu_out    = '0;
    store_data = '0;
    iord       = 1'b0;
    mem_rdata  = '0;
    clear_strobes();
    m_instr = '0;
    m_mdr   = '0;
    m_err   = 1'b0;
    #12;
    check_eq("reset_req", mem_req, 1'b0);
    check_eq("reset_we", mem_we, 1'b0);
    check_eq("reset_addr", mem_addr, '0);
    check_eq("reset_wdata", mem_wdata, '0);
    check_eq("reset_stall", stall, 1'b0);
    check_arch("reset");
    reset = 1'b1;
    next_cyc();

    // Fetch, zero wait states.
    access(1'b0, 1'b0, 32'h0000_0040, '0, 1'b1, 0, 32'h8C01_0004);
    idle_cyc(1'b0, 1'b0, 1'b0);
    // Load, 3 wait states: ready on the last cycle before abort.
    access(1'b0, 1'b1, 32'h0000_0104, '0, 1'b0, 3, 32'h1234_5678);
    // Store back-to-back.
    access(1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 1'b0, 2, 32'hFFFF_0000);
    // Timeout.
    access(1'b0, 1'b1, 32'h0000_0300, '0, 1'b1, 9, 32'hAAAA_5555);
    idle_cyc(1'b0, 1'b0, 1'b1);
    idle_cyc(1'b0, 1'b1, 1'b0);
    idle_cyc(1'b1, 1'b0, 1'b0);
    idle_cyc(1'b1, 1'b1, 1'b0);
    idle_cyc(1'b0, 1'b1, 1'b0);
    // Async reset mid-access, then a fresh fetch.
    reset_mid_access();
    access(1'b0, 1'b0, 32'h0000_0044, '0, 1'b1, 1, 32'h0BAD_F00D);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle_cyc(1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        access(1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom),
               int'($urandom_range(0, 5)), $urandom);
        if ($urandom_range(0, 1) == 0) idle_cyc(1'b0, 1'($urandom), 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_unit.md
# mem_port_unit

Multicycle-CPU memory port between the main controller and a variable-latency unified instruction/data memory. It turns the controller's single-cycle `memread`/`memwrite`/`IorD`/`IR_write` strobes into a registered request/ready handshake and holds the Instruction Register and Memory Data Register. While an access is outstanding it raises `stall`, and the controller state register and `pc_write`/`regwrite` enables are gated by it. A timeout counter aborts hung accesses and reports a sticky error.

## Interface
- `DW`, 32, data width (IR, MDR, memory data)
- `AW`, 32, byte address width; memory sees word address `AW-2` bits
- `TIMEOUT`, 16, max BUSY cycles before abort (≥2)
- `clk`  in  1  system clock; single clock domain, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `pc`  in  AW  fetch address
- `alu_out`  in  AW  data address (ALUOut register)
- `store_data`  in  DW  write data (B register)
- `IorD`  in  1  0 = fetch from `pc`, 1 = data access at `alu_out`
- `memread`, `memwrite`  in  1  controller access strobes
- `IR_write`  in  1  load read data into IR
- `err_clr`  in  1  clears `bus_err`
- `mem_req`  out  1  request valid to memory
- `mem_we`  out  1  1 = write
- `mem_addr`  out  AW-2  word address
- `mem_wdata`  out  DW  write data
- `mem_rdata`  in  DW  read data, valid with `mem_ready`
- `mem_ready`  in  1  access complete
- `instr`  out  DW  Instruction Register
- `mdr`  out  DW  Memory Data Register
- `stall`  out  1  controller must hold state and suppress writes
- `bus_err`  out  1  sticky error flag

## Operation
- Two states: IDLE, BUSY.
- IDLE, exactly one of `memread`/`memwrite` high:
  - latch address (`IorD ? alu_out : pc`) bits [AW-1:2], `memwrite` as `we`, `store_data`, and `IR_write`
  - clear the timeout counter and go to BUSY
  - address bits [1:0] are ignored; word access only
- IDLE, `memread` and `memwrite` both high: protocol error. Set `bus_err`, issue no request, stay IDLE.
- BUSY: `mem_req`=1 and all `mem_*` outputs are driven from the latched registers, stable until `mem_ready`.
- BUSY and `mem_ready`: go to IDLE.
  - read: `mdr` ← `mem_rdata`; also `instr` ← `mem_rdata` if the latched `IR_write`=1
  - write: `instr`/`mdr` unchanged
- BUSY, no `mem_ready`, counter = TIMEOUT-1: abort to IDLE. Set `bus_err`; `instr`/`mdr` unchanged.
- `mem_ready` in IDLE is ignored.
- `bus_err` clears on `err_clr`; a set event in the same cycle wins.
- Controller strobes are sampled only in IDLE. Strobes seen while BUSY are ignored; they are legal only because the controller is held by `stall`.

## Timing
- Reset (`reset`=0, asynchronous) gives:
  - state IDLE; `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0
  - `instr`=0, `mdr`=0, `bus_err`=0, counter 0
- Reset mid-access drops `mem_req` immediately and discards the access; memory must tolerate an abandoned request.
- `stall` is combinational: `(IDLE & (memread^memwrite)) | (BUSY & ~mem_ready & ~timeout_hit)`.
  - a new access stalls the controller in its issue cycle
  - `stall` falls in the cycle `mem_ready` arrives, so the controller advances on the same edge that loads IR/MDR
- Minimum access: issue edge (IDLE→BUSY), then `mem_ready` in the first BUSY cycle. Data is visible in `instr`/`mdr` one cycle after issue, i.e. 2 controller cycles per memory state.
- `mem_req` is registered; no combinational path from controller strobes to memory outputs.
- Back-to-back: a new request can issue in the IDLE cycle right after completion.
- Counter width is clog2(TIMEOUT) and increments each BUSY cycle without `mem_ready`. Abort occurs after TIMEOUT BUSY cycles; `mem_ready` in the abort cycle takes priority (completes normally).

## Structure
- Shared package `mips_mc_pkg`:
  - state enum `mem_state_t` {IDLE, BUSY}
  - word-address slice constants
  - default `TIMEOUT`
- One natural sub-module: `mem_timeout_cnt`, a loadable counter with clear, enable and a terminal-count flag. Everything else is flat.

## Test plan
- Fetch, 0 wait states:
  - stimulus: `pc`=0x0000_0040, `memread`=1, `IR_write`=1, `IorD`=0; `mem_ready`=1 in first BUSY cycle with `mem_rdata`=0x8C01_0004
  - response: `mem_addr`=0x10; `instr`=`mdr`=0x8C01_0004 next cycle; `stall` high exactly 1 cycle
- Load with 3 wait states:
  - stimulus: `IorD`=1, `alu_out`=0x0000_0104, `IR_write`=0
  - response: `mem_addr`=0x41 held 4 BUSY cycles; `mdr` updated, `instr` unchanged; `stall` high 4 cycles
- Store:
  - stimulus: `memwrite`=1, `alu_out`=0x200, `store_data`=0xDEAD_BEEF
  - response: `mem_we`=1, `mem_addr`=0x80, `mem_wdata`=0xDEAD_BEEF until `mem_ready`; `instr`/`mdr` unchanged
- Timeout:
  - stimulus: TIMEOUT=4, `mem_ready` held 0
  - response: return to IDLE after 4 BUSY cycles; `bus_err`=1 until `err_clr`; `instr`/`mdr` unchanged
- Error and ready priority:
  - stimulus: `memread`=`memwrite`=1 in IDLE
  - response: no `mem_req`, `bus_err`=1, `stall`=0
  - stimulus: `mem_ready` on the TIMEOUT-th BUSY cycle
  - response: normal completion, no error
- Async reset mid-access:
  - stimulus: `reset` low in the 2nd BUSY cycle
  - response: `mem_req`=0 before the next edge; `instr`=`mdr`=0; after release, a fresh fetch works
